// File: rtl/adc_reg_bank_if.sv
// Byte-wide register bus between the I2C slave core and the ADC register bank.
interface adc_reg_bank_if;
  logic [7:0] addr;
  logic [7:0] dataIn;
  logic       writeEn;
  logic       readEn;
  logic [7:0] dataOut;

  modport master (
    output addr,
    output dataIn,
    output writeEn,
    output readEn,
    input  dataOut
  );

  modport slave (
    input  addr,
    input  dataIn,
    input  writeEn,
    input  readEn,
    output dataOut
  );
endinterface

// File: rtl/adc_reg_bank.sv
// ADC front-end register bank: sample capture with sticky STATUS/OVERRUN flags,
// coherent 16-bit reads via an upper-byte snapshot, and manual/auto conversion starts.
module adc_reg_bank #(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned SAMPLE_W    = 12,
  parameter int unsigned AUTO_PERIOD = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  adc_reg_bank_if.slave                bus,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
  input  logic [NUM_CH-1:0]            sample_valid,
  output logic                         adc_start,
  output logic [2:0]                   adc_ch_sel,
  output logic                         adc_auto
);

  localparam int unsigned CNT_W       = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [7:0]  ADDR_STATUS = 8'h00;
  localparam logic [7:0]  ADDR_CMD    = 8'h01;
  localparam logic [7:0]  ADDR_OVR    = 8'h02;
  localparam logic [7:0]  ADDR_CH0    = 8'h04;
  localparam logic [3:0]  NUM_CH_L    = 4'(NUM_CH);
  localparam logic [2:0]  LAST_CH     = 3'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_PERIOD - 1);

  logic [SAMPLE_W-1:0] sample_q [NUM_CH];
  logic [SAMPLE_W-1:0] sample_d [NUM_CH];
  logic [NUM_CH-1:0]   status_q, status_d;
  logic [NUM_CH-1:0]   overrun_q, overrun_d;
  logic [2:0]          cmd_ch_q, cmd_ch_d;
  logic                cmd_auto_q, cmd_auto_d;
  logic [7:0]          lo_cand_q, lo_cand_d;
  logic [7:0]          lo_hold_q, lo_hold_d;
  logic [2:0]          hold_ch_q, hold_ch_d;
  logic                hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          auto_ch_q, auto_ch_d;
  logic                start_q, start_d;
  logic [2:0]          ch_sel_q, ch_sel_d;
  logic [7:0]          data_out_q;

  logic [7:0]          ch_off_c;
  logic [NUM_CH-1:0]   up_hit_c;
  logic [NUM_CH-1:0]   lo_hit_c;
  logic [7:0]          rd_data_c;
  logic [NUM_CH-1:0]   clr_status_c;
  logic [NUM_CH-1:0]   clr_overrun_c;
  logic                man_start_c;
  logic                auto_fire_c;
  logic                unused_data_bits_c;

  assign unused_data_bits_c = ^bus.dataIn;

  // Decode which channel's upper/lower byte the current address selects
  always_comb begin
    ch_off_c = bus.addr - ADDR_CH0;
    up_hit_c = '0;
    lo_hit_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.addr >= ADDR_CH0 && ch_off_c[7:1] == 7'(i)) begin
        up_hit_c[i] = ~ch_off_c[0];
        lo_hit_c[i] = ch_off_c[0];
      end
    end
  end

  // Read data mux; lower byte prefers the snapshot taken at the matching upper read
  always_comb begin
    rd_data_c = '0;
    case (bus.addr)
      ADDR_STATUS: rd_data_c = 8'(status_q);
      ADDR_CMD:    rd_data_c = {1'b0, cmd_auto_q, 3'b000, cmd_ch_q};
      ADDR_OVR:    rd_data_c = 8'(overrun_q);
      default:     ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (up_hit_c[i]) begin
        rd_data_c = 8'(sample_q[i] >> 8);
      end
      if (lo_hit_c[i]) begin
        rd_data_c = (hold_valid_q && hold_ch_q == 3'(i)) ? lo_hold_q : sample_q[i][7:0];
      end
    end
  end

  // Next-state logic: register writes, flags, snapshot and conversion scheduler
  always_comb begin
    sample_d      = sample_q;
    status_d      = status_q;
    overrun_d     = overrun_q;
    cmd_ch_d      = cmd_ch_q;
    cmd_auto_d    = cmd_auto_q;
    lo_cand_d     = lo_cand_q;
    lo_hold_d     = lo_hold_q;
    hold_ch_d     = hold_ch_q;
    hold_valid_d  = hold_valid_q;
    cnt_d         = cnt_q;
    auto_ch_d     = auto_ch_q;
    start_d       = 1'b0;
    ch_sel_d      = ch_sel_q;
    clr_status_c  = '0;
    clr_overrun_c = '0;
    man_start_c   = 1'b0;
    auto_fire_c   = 1'b0;

    if (bus.writeEn) begin
      if (bus.addr == ADDR_STATUS) begin
        clr_status_c = bus.dataIn[NUM_CH-1:0];
      end
      if (bus.addr == ADDR_OVR) begin
        clr_overrun_c = bus.dataIn[NUM_CH-1:0];
      end
      if (bus.addr == ADDR_CMD) begin
        cmd_ch_d    = bus.dataIn[2:0];
        cmd_auto_d  = bus.dataIn[6];
        man_start_c = bus.dataIn[7] && ({1'b0, bus.dataIn[2:0]} < NUM_CH_L);
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (up_hit_c[i]) begin
        lo_cand_d = sample_q[i][7:0];
        if (bus.readEn) begin
          lo_hold_d    = lo_cand_q;
          hold_ch_d    = 3'(i);
          hold_valid_d = 1'b1;
        end
      end
      if (lo_hit_c[i] && bus.readEn) begin
        hold_valid_d    = 1'b0;
        clr_status_c[i] = 1'b1;
      end
    end

    status_d  = status_q & ~clr_status_c;
    overrun_d = overrun_q & ~clr_overrun_c;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sample_valid[i]) begin
        sample_d[i] = sample_in[i*SAMPLE_W +: SAMPLE_W];
        if (status_q[i] && !clr_status_c[i]) begin
          overrun_d[i] = 1'b1;
        end
        status_d[i] = 1'b1;
      end
    end

    if (!cmd_auto_d) begin
      cnt_d     = '0;
      auto_ch_d = '0;
    end else if (man_start_c || !cmd_auto_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d       = '0;
      auto_fire_c = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (man_start_c) begin
      start_d  = 1'b1;
      ch_sel_d = cmd_auto_d ? auto_ch_q : bus.dataIn[2:0];
    end else if (auto_fire_c) begin
      start_d   = 1'b1;
      ch_sel_d  = auto_ch_q;
      auto_ch_d = (auto_ch_q == LAST_CH) ? 3'd0 : auto_ch_q + 3'd1;
    end else begin
      ch_sel_d = cmd_auto_d ? auto_ch_d : cmd_ch_d;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sample_q[i] <= '0;
      end
      status_q     <= '0;
      overrun_q    <= '0;
      cmd_ch_q     <= '0;
      cmd_auto_q   <= 1'b0;
      lo_cand_q    <= '0;
      lo_hold_q    <= '0;
      hold_ch_q    <= '0;
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
      auto_ch_q    <= '0;
      start_q      <= 1'b0;
      ch_sel_q     <= '0;
      data_out_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sample_q[i] <= sample_d[i];
      end
      status_q     <= status_d;
      overrun_q    <= overrun_d;
      cmd_ch_q     <= cmd_ch_d;
      cmd_auto_q   <= cmd_auto_d;
      lo_cand_q    <= lo_cand_d;
      lo_hold_q    <= lo_hold_d;
      hold_ch_q    <= hold_ch_d;
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
      auto_ch_q    <= auto_ch_d;
      start_q      <= start_d;
      ch_sel_q     <= ch_sel_d;
      data_out_q   <= rd_data_c;
    end
  end

  assign bus.dataOut = data_out_q;
  assign adc_start   = start_q;
  assign adc_ch_sel  = ch_sel_q;
  assign adc_auto    = cmd_auto_q;

endmodule
